// File: rtl/seg_serial_display_pkg.sv
// seg_serial_display_pkg: shared segment constants, hex glyph table and FSM state type
package seg_serial_display_pkg;
  localparam int SEG_DP = 7;
  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [7:0] HEX7 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
endpackage

// File: rtl/seg_serial_display_if.sv
// seg_serial_display_if: display register inputs and segment chain pins
interface seg_serial_display_if #(parameter int DIGITS = 8);
  logic start, auto_en, text_mode, flash;
  logic [4*DIGITS-1:0] hexs;
  logic [DIGITS-1:0] points, les;
  logic [8*DIGITS-1:0] seg_raw;
  logic segclk, segsout, segen, segclrn, busy, done;
  modport master (output start, auto_en, text_mode, flash, hexs, points, les, seg_raw,
                  input segclk, segsout, segen, segclrn, busy, done);
  modport slave (input start, auto_en, text_mode, flash, hexs, points, les, seg_raw,
                 output segclk, segsout, segen, segclrn, busy, done);
endinterface

// File: rtl/seg_serial_display_hex_decode.sv
// seg_hex_decode: nibble plus decimal point to active-low segment byte
module seg_hex_decode
  import seg_serial_display_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       point,
  output logic [7:0] seg
);
  assign seg = HEX7[hex] & ~(8'(point) << SEG_DP);
endmodule

// File: rtl/seg_serial_display.sv
// seg_serial_display: builds an N-digit segment frame and shifts it out to a serial chain
module seg_serial_display
  import seg_serial_display_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int SCLK_DIV = 2,
  parameter int REFRESH_CYC = 1000000,
  parameter int BLINK_BITS = 24
) (
  input logic clk,
  input logic rst,
  seg_serial_display_if.slave bus
);
  localparam int FRAME = 8 * DIGITS;
  localparam int BW = $clog2(FRAME);
  localparam int DW = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
  localparam int RW = $clog2(REFRESH_CYC);
  state_t state;
  logic [FRAME-1:0] frame, sh;
  logic [7:0] dec [DIGITS];
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [RW-1:0] ref_cnt;
  logic [BLINK_BITS-1:0] blink;
  logic pend, tick, trig, last_div;
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_dig
    seg_hex_decode u_dec (.hex(bus.hexs[4*i+:4]), .point(bus.points[i]), .seg(dec[i]));
    assign frame[8*i+:8] = bus.flash && blink[BLINK_BITS-1] && bus.les[i] ? BLANK :
                           bus.text_mode ? bus.seg_raw[8*i+:8] : dec[i];
  end
  assign tick = bus.auto_en && ref_cnt == RW'(REFRESH_CYC - 1);
  assign trig = bus.start || tick;
  assign last_div = div_cnt == DW'(SCLK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.segclk <= 1'b0;
      bus.segsout <= 1'b1;
      bus.segen <= 1'b0;
      bus.segclrn <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      pend <= 1'b0;
      sh <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ref_cnt <= '0;
      blink <= '0;
    end else begin
      blink <= blink + 1'b1;
      if (bus.auto_en) ref_cnt <= tick ? '0 : ref_cnt + 1'b1;
      bus.done <= 1'b0;
      if (trig && state != IDLE) pend <= 1'b1;
      case (state)
        IDLE: if (trig || pend) begin
          state <= LOAD;
          pend <= 1'b0;
        end
        LOAD: begin
          sh <= frame;
          bus.segsout <= frame[FRAME-1];
          bus.busy <= 1'b1;
          bus.segen <= 1'b0;
          bus.segclrn <= 1'b1;
          bus.segclk <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          div_cnt <= last_div ? '0 : div_cnt + 1'b1;
          if (last_div) bus.segclk <= ~bus.segclk;
          // end of the high phase: advance to the next bit, or finish after the last one
          if (last_div && bus.segclk) begin
            sh <= {sh[FRAME-2:0], 1'b1};
            bus.segsout <= sh[FRAME-2];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(FRAME - 1)) state <= LATCH;
          end
        end
        LATCH: begin
          bus.segen <= 1'b1;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          bus.segsout <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/seg_serial_display.md
Name: seg_serial_display

Overview:
Parametrised serial seven-segment display driver, replacing the fixed 8-digit hex/text display path.
- Builds an N-digit segment frame from either hex nibbles (internal decode) or raw segment bytes.
- Applies per-digit blinking from an internal blink timer.
- Shifts the frame out to the external shift-register chain, on request or on a periodic auto-refresh timer.
- Sits between the CPU-visible display registers and the board segment shift-register pins.

Parameters:
DIGITS, 8, number of digits; frame length is 8*DIGITS bits.
SCLK_DIV, 2, segclk half-period in clk cycles (>=1).
REFRESH_CYC, 1000000, auto-refresh period in clk cycles (>=16*DIGITS*SCLK_DIV+4).
BLINK_BITS, 24, width of the free-running blink counter; its MSB is the blink phase.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle frame request.
auto_en  in  1  enables periodic refresh every REFRESH_CYC cycles.
text_mode  in  1  0 = hex decode of hexs; 1 = raw bytes from seg_raw.
flash  in  1  global blink enable.
hexs  in  4*DIGITS  nibble i = digit i.
points  in  DIGITS  1 = decimal point lit on digit i (hex mode only).
les  in  DIGITS  1 = digit i blinks when flash=1.
seg_raw  in  8*DIGITS  byte i = active-low segments of digit i, {dp,g,f,e,d,c,b,a}.
segclk  out  1  shift clock to external chain.
segsout  out  1  serial data, valid across the segclk rising edge.
segen  out  1  display output enable; 0 while shifting.
segclrn  out  1  active-low clear of the external chain.
busy  out  1  frame in progress.
done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset values: segclk=0, segsout=1, segen=0, segclrn=0, busy=0, done=0. Reset also clears all counters, the pending flag, and the shift register. Reset mid-frame aborts the frame immediately with the same values.
- segclrn stays 0 from reset until the first LOAD, then stays 1. segen goes 1 at the first LATCH and is 0 in LOAD/SHIFT.
- Hex decode uses active-low segments, {dp,g,f,e,d,c,b,a}:
  - 0 -> C0, 1 -> F9, 2 -> A4, 3 -> B0, 4 -> 99, 5 -> 92, 6 -> 82, 7 -> F8, 8 -> 80, 9 -> 90, A -> 88, b -> 83, C -> C6, d -> A1, E -> 86, F -> 8E.
  - points[i]=1 clears bit7.
- Blink: counter free-runs, wrapping at 2^BLINK_BITS. When flash=1, the counter MSB=1 and les[i]=1, digit i is forced to FF (blank) in both modes.
- Trigger sources:
  - start=1 in IDLE.
  - auto_en=1 and the refresh counter reaches REFRESH_CYC-1. The counter resets to 0 on the trigger and counts only while auto_en=1.
- A trigger arriving while busy sets a pending flag; multiple requests merge into one. The pending request starts LOAD on the cycle after LATCH.
- FSM:
  - IDLE: on trigger or pending -> LOAD.
  - LOAD (1 cycle): snapshot the whole frame into the shift register (later input changes do not affect this frame). Set busy=1, segen=0, segsout = frame MSB (bit7 of digit DIGITS-1), segclk=0 -> SHIFT.
  - SHIFT: each bit is held SCLK_DIV cycles with segclk=0, then SCLK_DIV cycles with segclk=1. After the high phase, shift left and present the next bit. Order is digit DIGITS-1 down to 0, bit7 down to bit0. After bit 8*DIGITS-1 completes its high phase -> LATCH, with segclk=0.
  - LATCH (1 cycle): segen=1, done=1, busy=0 next cycle, segsout=1 -> IDLE.
- Frame length: 2 + 16*DIGITS*SCLK_DIV cycles from LOAD entry to IDLE re-entry.
- start and an auto-refresh tick in the same cycle count as one request.

Decomposition:
- Shared package holds: segment bit-order constants, the BLANK=8'hFF constant, and the FSM state enum (IDLE, LOAD, SHIFT, LATCH).
- One sub-module, seg_hex_decode: combinational nibble+point -> active-low byte, instantiated per digit by generate.
- The serial shifter/FSM stays in the top.

Test Plan:
- Reset, then start with DIGITS=8, SCLK_DIV=2, text_mode=0, hexs=0x0123ABCF, points=0 -> 64 segclk rising edges sampling bytes C0,F9,A4,B0,88,83,C6,8E MSB-first; done pulses exactly once, 258 cycles after LOAD.
- Same frame with points=8'h01 -> last byte sampled 0E; segclrn 0 before the first LOAD and 1 after.
- text_mode=1, seg_raw=0x00FF00FF00FF00FF, flash=1, les=8'h0F, blink MSB forced 1 (BLINK_BITS=4) -> bytes 00,FF,00,FF,FF,FF,FF,FF.
- start pulsed twice during a frame -> exactly one extra frame begins the cycle after done; hexs changed mid-frame does not alter the current frame's bits.
- auto_en=1, REFRESH_CYC=300, DIGITS=8, SCLK_DIV=2 -> a LOAD every 300 cycles with no start input; rst asserted mid-SHIFT -> next cycle segclk=0, segsout=1, segen=0, segclrn=0, busy=0.
